// File: rtl/bus_pkg.sv
// Shared types and constants for the serial bus master port.
package bus_pkg;

  localparam int DEF_ADDR_WIDTH = 14;
  localparam int DEF_DATA_WIDTH = 8;

  localparam logic MODE_WRITE = 1'b1;
  localparam logic MODE_READ  = 1'b0;

  typedef enum logic [3:0] {
    IDLE,
    REQ,
    ADDR,
    MODE,
    WDATA,
    WACK,
    RDATA,
    DONE,
    ABORT
  } state_t;

endpackage

// File: rtl/bit_shift_reg.sv
// Parallel-load shift register; shifts toward bit 0 so bit 0 leaves first
// and serial input bits enter at the MSB (LSB-first assembly).
module bit_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_data,
  input  logic             i_shift,
  input  logic             i_shift_in,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_load_data;
    end else if (i_shift) begin
      r_q <= {i_shift_in, r_q[WIDTH-1:1]};
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/bus_master_port.sv
// One serial bus transaction per enable: request, address, mode, data,
// then slave response. Reports done/error pulses and the last read byte.
module bus_master_port
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TIMEOUT    = 63
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  read_en,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  bus_grant,
  output logic                  bus_request,
  output logic                  m_valid,
  output logic                  m_out,
  input  logic                  s_ready,
  input  logic                  s_valid,
  input  logic                  s_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  done,
  output logic                  error,
  output logic                  busy
);

  localparam int CW = $clog2(ADDR_WIDTH + 1);

  state_t                r_state;
  logic                  r_read;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [CW-1:0]         r_cnt;
  logic [7:0]            r_wait;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_m_valid;
  logic                  r_m_out;

  logic                  w_start;
  logic                  w_tx_load;
  logic                  w_tx_shift;
  logic [ADDR_WIDTH-1:0] w_tx_load_data;
  logic [ADDR_WIDTH-1:0] w_tx_q;
  logic                  w_rx_shift;
  logic [DATA_WIDTH-1:0] w_rx_q;
  logic                  w_grant_lost;
  logic                  w_wait_hit;
  logic                  w_addr_last;
  logic                  w_data_last;
  logic                  w_unused_bits;

  assign w_start     = (r_state == IDLE) && enable;
  assign w_addr_last = (r_cnt == CW'(ADDR_WIDTH - 1));
  assign w_data_last = (r_cnt == CW'(DATA_WIDTH - 1));
  assign w_wait_hit  = (r_wait == 8'(TIMEOUT - 1));

  assign w_grant_lost = !bus_grant &&
                        (r_state inside {ADDR, MODE, WDATA, WACK, RDATA});

  // Address is loaded at start; write data replaces it on the last address bit.
  assign w_tx_load      = w_start || ((r_state == ADDR) && bus_grant && w_addr_last);
  assign w_tx_load_data = w_start ? addr_in : ADDR_WIDTH'(r_wdata);
  assign w_tx_shift     = bus_grant &&
                          ((r_state == REQ) || (r_state == ADDR) ||
                           ((r_state == MODE) && !r_read) || (r_state == WDATA));
  assign w_rx_shift     = (r_state == RDATA) && bus_grant && s_valid;

  bit_shift_reg #(.WIDTH(ADDR_WIDTH)) u_tx_sreg (
    .clk         (clk),
    .reset       (reset),
    .i_load      (w_tx_load),
    .i_load_data (w_tx_load_data),
    .i_shift     (w_tx_shift),
    .i_shift_in  (1'b0),
    .o_q         (w_tx_q)
  );

  bit_shift_reg #(.WIDTH(DATA_WIDTH)) u_rx_sreg (
    .clk         (clk),
    .reset       (reset),
    .i_load      (w_start),
    .i_load_data ('0),
    .i_shift     (w_rx_shift),
    .i_shift_in  (s_in),
    .o_q         (w_rx_q)
  );

  assign w_unused_bits = ^{w_tx_q[ADDR_WIDTH-1:1], w_rx_q[0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_read     <= 1'b0;
      r_wdata    <= '0;
      r_cnt      <= '0;
      r_wait     <= '0;
      r_data_out <= '0;
      r_m_valid  <= 1'b0;
      r_m_out    <= 1'b0;
    end else if (w_grant_lost) begin
      r_state   <= ABORT;
      r_m_valid <= 1'b0;
      r_m_out   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_m_valid <= 1'b0;
          r_m_out   <= 1'b0;
          r_cnt     <= '0;
          r_wait    <= '0;
          if (enable) begin
            r_read  <= read_en;
            r_wdata <= data_in;
            r_state <= REQ;
          end
        end
        REQ: begin
          if (bus_grant) begin
            r_state   <= ADDR;
            r_m_valid <= 1'b1;
            r_m_out   <= w_tx_q[0];
            r_cnt     <= '0;
          end
        end
        ADDR: begin
          if (w_addr_last) begin
            r_state <= MODE;
            r_m_out <= r_read ? MODE_READ : MODE_WRITE;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
            r_m_out <= w_tx_q[0];
          end
        end
        MODE: begin
          r_cnt  <= '0;
          r_wait <= '0;
          if (r_read) begin
            r_state   <= RDATA;
            r_m_valid <= 1'b0;
            r_m_out   <= 1'b0;
          end else begin
            r_state <= WDATA;
            r_m_out <= w_tx_q[0];
          end
        end
        WDATA: begin
          if (w_data_last) begin
            r_state   <= WACK;
            r_m_valid <= 1'b0;
            r_m_out   <= 1'b0;
            r_wait    <= '0;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
            r_m_out <= w_tx_q[0];
          end
        end
        WACK: begin
          // A late acknowledge on the final wait cycle still wins.
          if (s_ready)         r_state <= DONE;
          else if (w_wait_hit) r_state <= ABORT;
          else                 r_wait  <= r_wait + 1'b1;
        end
        RDATA: begin
          if (s_valid) begin
            r_wait <= '0;
            if (w_data_last) begin
              r_state    <= DONE;
              r_data_out <= {s_in, w_rx_q[DATA_WIDTH-1:1]};
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end else if (w_wait_hit) begin
            r_state <= ABORT;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        DONE:    r_state <= IDLE;
        ABORT:   r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign m_valid     = r_m_valid;
  assign m_out       = r_m_out;
  assign data_out    = r_data_out;
  assign done        = (r_state == DONE);
  assign error       = (r_state == ABORT);
  assign busy        = (r_state != IDLE);
  assign bus_request = r_state inside {REQ, ADDR, MODE, WDATA, WACK, RDATA};

endmodule

// File: tb/tb_bus_master_port.sv
// Bench for bus_master_port: directed scenarios plus randomized transactions
// checked against a transaction-level timing and framing model.
module tb_bus_master_port;

  localparam int AW = 14;
  localparam int DW = 8;
  localparam int TO = 63;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          read_en;
  logic [AW-1:0] addr_in;
  logic [DW-1:0] data_in;
  logic          bus_grant;
  logic          bus_request;
  logic          m_valid;
  logic          m_out;
  logic          s_ready;
  logic          s_valid;
  logic          s_in;
  logic [DW-1:0] data_out;
  logic          done;
  logic          error;
  logic          busy;

  always #5 clk = ~clk;

  bus_master_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .read_en     (read_en),
    .addr_in     (addr_in),
    .data_in     (data_in),
    .bus_grant   (bus_grant),
    .bus_request (bus_request),
    .m_valid     (m_valid),
    .m_out       (m_out),
    .s_ready     (s_ready),
    .s_valid     (s_valid),
    .s_in        (s_in),
    .data_out    (data_out),
    .done        (done),
    .error       (error),
    .busy        (busy)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit mq[$];
  int mv_first;
  int done_q[$];
  int err_q[$];

  always @(negedge clk) begin
    if (m_valid) begin
      if (mq.size() == 0) mv_first = cyc;
      mq.push_back(m_out);
    end
    if (done)  done_q.push_back(cyc);
    if (error) err_q.push_back(cyc);
  end

  int n_chk = 0;
  int n_pass = 0;
  logic [DW-1:0] last_rd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Serial frame: address LSB first, mode bit, then write data LSB first.
  function automatic logic [31:0] frame_bits(input bit rd, input logic [AW-1:0] a,
                                             input logic [DW-1:0] d, output int n);
    logic [31:0] f;
    f = 32'd0;
    n = 0;
    for (int i = 0; i < AW; i++) begin
      f = f | (32'((a >> i) & 1) << n);
      n++;
    end
    f = f | (32'(rd ? 0 : 1) << n);
    n++;
    if (!rd) begin
      for (int i = 0; i < DW; i++) begin
        f = f | (32'((d >> i) & 1) << n);
        n++;
      end
    end
    return f;
  endfunction

  task automatic run_txn(input bit rd, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int gdel, input int rdel, input int drop_idx,
                         input int gap_mode, input int busy_en);
    int t0, g, mode_c, wack, ready_c, drop_c, exp_done, exp_err, end_c, c, n_exp;
    int vc[DW];
    bit req_ok, abort_ok;
    logic [31:0] exp_f, got_f;
    mq.delete(); done_q.delete(); err_q.delete(); mv_first = -1;
    @(posedge clk); #1;
    t0 = cyc;
    enable = 1'b1; read_en = rd; addr_in = a; data_in = d;
    bus_grant = (gdel == 0); s_ready = 1'b0; s_valid = 1'b0;
    g      = t0 + 1 + gdel;
    mode_c = g + 1 + AW;
    wack   = mode_c + 1 + DW;
    drop_c  = (drop_idx >= 0) ? g + 1 + drop_idx : (1 << 30);
    ready_c = (!rd && rdel < TO) ? wack + rdel : -1;
    c = mode_c + 1;
    for (int i = 0; i < DW; i++) begin
      if (gap_mode == 1)      c += (i == 4) ? 2 : 0;
      else if (gap_mode == 2) c += $urandom_range(0, 3);
      vc[i] = c;
      c++;
    end
    exp_done = -1; exp_err = -1;
    if (drop_idx >= 0)  exp_err  = drop_c + 1;
    else if (rd)        exp_done = vc[DW-1] + 1;
    else if (ready_c >= 0) exp_done = ready_c + 1;
    else                exp_err  = wack + TO;
    end_c = ((exp_done > exp_err) ? exp_done : exp_err) + 3;
    exp_f = frame_bits(rd, a, d, n_exp);
    if (drop_idx >= 0) begin
      n_exp = drop_idx + 1;
      exp_f = exp_f & ((32'd1 << n_exp) - 32'd1);
    end
    req_ok = 1'b1; abort_ok = 1'b1;
    while (cyc < end_c) begin
      @(posedge clk); #1;
      enable    = (busy_en >= 0 && cyc == t0 + busy_en);
      read_en   = 1'($urandom);
      addr_in   = AW'($urandom);
      data_in   = DW'($urandom);
      bus_grant = (cyc >= g && cyc < drop_c);
      s_ready   = (cyc == ready_c);
      s_valid   = 1'b0;
      s_in      = 1'($urandom);
      if (rd) begin
        for (int i = 0; i < DW; i++) begin
          if (cyc == vc[i]) begin
            s_valid = 1'b1;
            s_in    = d[i];
          end
        end
      end
      @(negedge clk);
      if (cyc > t0 && cyc <= g && !(bus_request && !m_valid)) req_ok = 1'b0;
      if (drop_idx >= 0 && cyc == exp_err && (m_valid || bus_request || !error)) abort_ok = 1'b0;
    end
    got_f = 32'd0;
    foreach (mq[i]) if (i < 32) got_f[i] = mq[i];
    chk("m_bit_count", 32'(mq.size()), 32'(n_exp));
    chk("m_bit_stream", got_f, exp_f);
    chk("first_addr_bit_cycle", 32'(mv_first), 32'(g + 1));
    chk("req_phase", 32'(req_ok), 32'd1);
    if (exp_done >= 0) begin
      chk("done_count", 32'(done_q.size()), 32'd1);
      if (done_q.size() > 0) chk("done_cycle", 32'(done_q[0]), 32'(exp_done));
      chk("error_count", 32'(err_q.size()), 32'd0);
      if (rd) last_rd = d;
    end else begin
      chk("error_count", 32'(err_q.size()), 32'd1);
      if (err_q.size() > 0) chk("error_cycle", 32'(err_q[0]), 32'(exp_err));
      chk("done_count", 32'(done_q.size()), 32'd0);
    end
    if (drop_idx >= 0) chk("abort_outputs", 32'(abort_ok), 32'd1);
    chk("data_out", 32'(data_out), 32'(last_rd));
    chk("idle_after", 32'({busy, bus_request, m_valid}), 32'd0);
  endtask

  task automatic reset_mid_read();
    mq.delete(); done_q.delete(); err_q.delete();
    @(posedge clk); #1;
    enable = 1'b1; read_en = 1'b1; addr_in = AW'($urandom); data_in = DW'($urandom);
    bus_grant = 1'b1; s_valid = 1'b0; s_ready = 1'b0;
    repeat (AW + 5) begin
      @(posedge clk); #1;
      enable = 1'b0;
      s_valid = 1'($urandom);
      s_in = 1'($urandom);
    end
    chk("busy_in_rdata", 32'(busy), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("reset_mid_read_outs",
        32'({busy, done, error, bus_request, m_valid, m_out, data_out}), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1; s_valid = 1'b0;
    last_rd = '0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("no_pulse_after_reset", 32'(done_q.size() + err_q.size()), 32'd0);
    chk("idle_after_reset", 32'(busy), 32'd0);
  endtask

  initial begin
    bit rd;
    int gdel, rdel, drop;
    reset = 1'b0; enable = 1'b0; read_en = 1'b0; addr_in = '0; data_in = '0;
    bus_grant = 1'b0; s_ready = 1'b0; s_valid = 1'b0; s_in = 1'b0;
    last_rd = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", 32'({busy, done, error, bus_request, m_valid, m_out}), 32'd0);
    chk("reset_data_out", 32'(data_out), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    run_txn(1'b0, 14'h0155, 8'hA5, 0, 0, -1, 0, -1);
    run_txn(1'b1, 14'h2001, 8'h3C, 0, 0, -1, 1, -1);
    run_txn(1'b0, AW'($urandom), DW'($urandom), 10, 3, -1, 0, -1);
    run_txn(1'b0, AW'($urandom), DW'($urandom), 0, TO + 10, -1, 0, -1);
    run_txn(1'b0, AW'($urandom), DW'($urandom), 0, TO - 1, -1, 0, -1);
    run_txn(1'b0, AW'($urandom), DW'($urandom), 0, TO, -1, 0, -1);
    run_txn(1'b0, AW'($urandom), DW'($urandom), 0, 0, 5, 0, -1);
    run_txn(1'b0, AW'($urandom), DW'($urandom), 0, 2, -1, 0, -1);
    run_txn(1'b1, AW'($urandom), DW'($urandom), 1, 0, -1, 2, 5);
    reset_mid_read();

    for (int k = 0; k < 24; k++) begin
      rd   = 1'($urandom_range(0, 1));
      gdel = $urandom_range(0, 4);
      rdel = ($urandom_range(0, 5) == 0) ? TO + $urandom_range(0, 3) : $urandom_range(0, 12);
      drop = ($urandom_range(0, 5) == 0) ? $urandom_range(0, AW - 1) : -1;
      run_txn(rd, AW'($urandom), DW'($urandom), gdel, rdel, drop, 2, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bus_master_port.md
Name: bus_master_port

Overview:
- Master-side port that sits directly downstream of the bus controller. It consumes the controller's per-master enable, read_en, addr_in and data_in, and executes one serial bus transaction per enable.
- Per transaction it requests the bus from the arbiter, waits for grant, shifts out address, mode and write data serially, then waits for the slave response.
- It returns read data and completion/error status to the controller side. One instance is built per master (m1, m2).

Parameters:
- ADDR_WIDTH, 14, address bits shifted per transaction (matches addr_in width)
- DATA_WIDTH, 8, data bits per transaction (matches data_in width)
- TIMEOUT, 63, max cycles waited for slave ready, or between read bits, before abort

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- enable  input  1  start-of-transaction strobe from controller; sampled only in IDLE
- read_en  input  1  1 = read, 0 = write; latched with enable
- addr_in  input  ADDR_WIDTH  target address; latched with enable
- data_in  input  DATA_WIDTH  write data; latched with enable
- bus_grant  input  1  arbiter grant for this master
- bus_request  output  1  request to arbiter
- m_valid  output  1  serial master bit valid
- m_out  output  1  serial master bit (address, then mode, then write data)
- s_ready  input  1  slave write acknowledge
- s_valid  input  1  slave read bit valid
- s_in  input  1  slave read data bit
- data_out  output  DATA_WIDTH  last successfully read byte
- done  output  1  one-cycle pulse on successful completion
- error  output  1  one-cycle pulse on abort (timeout or grant loss)
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset: reset=0 asynchronously forces state IDLE. It also clears bus_request, m_valid, m_out, done, error, busy, data_out, all counters and shift registers.
- Reset applied mid-transaction abandons the transaction. No done or error pulse is produced.
- IDLE:
  - enable=1 at a posedge latches read_en, addr_in and data_in. The next state is REQ.
  - enable is ignored in every state other than IDLE.
- REQ:
  - bus_request=1.
  - bus_grant=1 sampled -> ADDR. Otherwise stay in REQ; there is no timeout in REQ.
- ADDR:
  - ADDR_WIDTH cycles, m_valid=1, m_out = address bit, LSB first.
  - The first bit is driven in the cycle after grant is sampled.
- MODE: 1 cycle, m_valid=1, m_out = 1 for write, 0 for read.
- Write path:
  - WDATA: DATA_WIDTH cycles, m_valid=1, m_out = data bit, LSB first.
  - Then WACK: m_valid=0. s_ready=1 -> DONE.
- Read path:
  - RDATA: m_valid=0. Each cycle with s_valid=1 shifts s_in into the internal register, LSB first. Cycles with s_valid=0 are gaps and are allowed.
  - After DATA_WIDTH valid bits -> DONE. data_out loads the assembled byte on entry to DONE.
- DONE:
  - done=1 for 1 cycle, bus_request=0, then IDLE.
  - Back-to-back: enable is accepted in the IDLE cycle that follows DONE.
- Timeout:
  - An 8-bit wait counter clears on entry to WACK and on each valid read bit.
  - If the counter reaches TIMEOUT in WACK or RDATA -> ABORT.
- Grant loss: bus_grant=0 in any cycle of ADDR, MODE, WDATA, WACK or RDATA -> ABORT.
- ABORT:
  - error=1 for 1 cycle. bus_request=0, m_valid=0, data_out unchanged. Then IDLE.
- Simultaneous events: grant loss and timeout in the same cycle produce a single error pulse. s_ready=1 in the same cycle as the timeout hit counts as success.
- Timing: m_out and m_valid are registered outputs; done, error and busy are decoded directly from state.
- Write latency with grant already high:
  - enable in cycle 0, REQ cycle 1, ADDR cycles 2–15, MODE cycle 16, WDATA cycles 17–24.
  - WACK from cycle 25. With s_ready=1 at 25, DONE (done=1) is in cycle 26.

Decomposition:
- Shared package bus_pkg holds:
  - the state enum (IDLE, REQ, ADDR, MODE, WDATA, WACK, RDATA, DONE, ABORT);
  - ADDR_WIDTH and DATA_WIDTH defaults;
  - the MODE_WRITE=1 / MODE_READ=0 constants.
- One natural sub-module, bit_shift_reg: a parameterised shift register with load, shift-out (LSB first) and shift-in-with-enable. It is instantiated once for address/write-data serialisation and once for read-data assembly.

Test Plan:
- Write, grant held high: enable with addr_in=14'h0155, data_in=8'hA5, read_en=0; s_ready=1 at cycle 25.
  -> m_out sequence is 1,0,1,0,1,0,1,0,1,0,0,0,0,0 (address), then 1 (mode), then 1,0,1,0,0,1,0,1 (data). done pulses in cycle 26; bus_request low after DONE.
- Read with gaps: addr_in=14'h2001, read_en=1; slave sends 8'h3C LSB first, with s_valid low for 2 cycles after bit 3.
  -> data_out=8'h3C, done pulses once, error stays 0.
- Delayed grant: bus_grant held 0 for 10 cycles after enable.
  -> bus_request=1 and m_valid=0 throughout. The first address bit appears the cycle after grant rises.
- Timeout: write transaction with s_ready never asserted.
  -> error pulses exactly TIMEOUT cycles after WACK entry, then busy=0 and data_out unchanged.
- Grant loss: bus_grant dropped in ADDR cycle 5.
  -> next cycle shows error=1, m_valid=0, bus_request=0. A new enable 2 cycles later is accepted normally.
- Reset mid-read: reset=0 during RDATA, then released; enable asserted while busy in a separate run.
  -> all outputs 0 immediately with no done/error pulse. The enable asserted while busy is ignored (no second transaction).
